free_list_mp: RTL and testbench
===============================

FREE_LIST_MP -- requirements
Module: free_list_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 7, width of one physical register tag.
REQ-002 SHALL have parameter RAM_DEPTH, default 128, number of entries (power of two, equal to the physical register count).
REQ-003 SHALL have parameter L_REGISTERS, default 32, number of tags held outside the list at reset.
REQ-004 SHALL have parameter PUSH_LANES, default 2, number of push lanes per cycle.
REQ-005 SHALL have parameter POP_LANES, default 2, number of pop lanes per cycle.
REQ-006 SHALL have parameter CKPT_COUNT, default 4, number of head-pointer checkpoints.
REQ-007 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- push  in  PUSH_LANES  per-lane push request; any mask allowed.
- push_data  in  PUSH_LANES x DATA_WIDTH  freed tags.
- ready  out  1  at least PUSH_LANES free slots.
- pop  in  POP_LANES  per-lane pop request; thermometer mask from lane 0.
- pop_data  out  POP_LANES x DATA_WIDTH  tag at head+i for lane i.
- pop_valid  out  POP_LANES  lane i valid when count > i.
- ckpt_save  in  1  save head into ckpt_id.
- ckpt_restore  in  1  restore head from ckpt_id.
- ckpt_id  in  clog2(CKPT_COUNT)  checkpoint slot.
- count  out  clog2(RAM_DEPTH)+1  entries currently held.

Function
REQ-008 SHALL hold head and tail as binary pointers of clog2(RAM_DEPTH)+1 bits (wrap bit); count = tail - head, mod 2*RAM_DEPTH.
REQ-009 SHALL drive pop_data[i] combinationally from mem[(head+i) mod RAM_DEPTH], with zero-cycle read latency.
REQ-010 SHALL advance head by popcount(pop) at the clock edge; pop_data SHALL reflect the new head in the next cycle.
REQ-011 SHALL compact active push lanes in lane order: the k-th set lane writes mem[(tail+k) mod RAM_DEPTH]; tail advances by popcount(push).
REQ-012 SHALL update ready = (RAM_DEPTH - count) >= PUSH_LANES, and pop_valid, from registered state only.
REQ-013 SHALL perform simultaneous push and pop in one cycle; count_next = count + popcount(push) - popcount(pop).
REQ-014 SHALL, on ckpt_save, store head_next (the head after this cycle's pops) into ckpt[ckpt_id].
REQ-015 SHALL, on ckpt_restore, set head <= ckpt[ckpt_id], ignore pop that cycle, still accept push, and recompute count from the restored head.
REQ-016 SHALL ignore ckpt_save when ckpt_restore is asserted in the same cycle.
REQ-017 SHALL rely on the invariant that tags never exceed RAM_DEPTH, so entries between a saved head and the current head are never overwritten before restore.
REQ-018 SHALL wrap head, tail and lane offsets modulo RAM_DEPTH, with no bubble at the wrap boundary.
REQ-019 SHALL treat the following as illegal, checked by assertions: pop lane i without pop_valid[i]; a non-thermometer pop mask; any push while ready is low; PUSH_LANES or POP_LANES of 0.

Reset
REQ-020 SHALL, on rst, set head=0, tail=RAM_DEPTH-L_REGISTERS, count=RAM_DEPTH-L_REGISTERS, all ckpt=0, and mem[j]=j+L_REGISTERS for j<RAM_DEPTH-L_REGISTERS.
REQ-021 SHALL, during reset, drive ready=1 and pop_valid all ones (defaults), with pop_data[i]=L_REGISTERS+i.
REQ-022 SHALL, when rst is asserted mid-operation, discard in-flight push, pop, save and restore operations immediately.

Structure
REQ-023 SHALL take the ptr_t and tag_t typedefs and the reset constants from the shared rename package.
REQ-024 SHALL use one sub-module, lane_compactor, that maps the push mask to per-lane write offsets and popcount.

Verification
REQ-025 SHALL cover: reset with no stimulus -> count=96, pop_data={33,32} (lane1,lane0), pop_valid=2'b11, ready=1.
REQ-026 SHALL cover: pop=2'b01, then pop=2'b11 -> pop_data[0]=33, then pop_data[0]=35, count=93.
REQ-027 SHALL cover: push=2'b10, push_data[1]=5, with count=96 -> mem[96]=5, count=97; after popping 96 entries, pop_data[0]=5.
REQ-028 SHALL cover: ckpt_save id 2 at head=0 with no pop; pop 2'b11 three times; ckpt_restore id 2 -> pop_data[0]=32, count=96.
REQ-029 SHALL cover: fill with 32 pushes to count=128 -> ready=0 once count>126; a simultaneous push 2'b11 and pop 2'b11 at count=126 keeps count=126.
REQ-030 SHALL cover: 200 cycles of random push/pop across tail wrap at 127->0 -> tag multiset conserved, no assertion fires.

Source files
------------

// File: rtl/free_list_mp_pkg.sv
// ============================================================================
// Module  : free_list_mp_pkg
// Brief   : Shared rename types, default sizes and reset helpers for the
//           physical-register free list.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package free_list_mp_pkg;
  localparam int FL_DATA_WIDTH  = 7;
  localparam int FL_RAM_DEPTH   = 128;
  localparam int FL_L_REGISTERS = 32;
  localparam int FL_PTR_WIDTH   = $clog2(FL_RAM_DEPTH) + 1;

  typedef logic [FL_DATA_WIDTH-1:0] tag_t;
  typedef logic [FL_PTR_WIDTH-1:0]  ptr_t;

  localparam ptr_t RST_HEAD = '0;

  // Tags below L_REGISTERS start out mapped to architectural registers.
  function automatic tag_t reset_tag(input int j, input int l_regs);
    return tag_t'(j + l_regs);
  endfunction
endpackage

`default_nettype wire

// File: rtl/lane_compactor.sv
// ============================================================================
// Module  : lane_compactor
// Brief   : Maps a push lane mask to per-lane compacted write offsets and
//           the total number of active lanes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_compactor #(
  parameter int LANES = 2,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]    mask_i,
  output logic [LANES*CW-1:0] offset_o,
  output logic [CW-1:0]       count_o
);

  logic [CW-1:0] run_w;

  always_comb begin
    run_w    = '0;
    offset_o = '0;
    for (int i = 0; i < LANES; i++) begin
      offset_o[i*CW +: CW] = run_w;
      run_w = run_w + CW'(mask_i[i]);
    end
    count_o = run_w;
  end

endmodule

`default_nettype wire

// File: rtl/free_list_mp.sv
// ============================================================================
// Module  : free_list_mp
// Brief   : Multi-port circular free list of physical register tags with
//           head-pointer checkpoints for rename recovery.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module free_list_mp
  import free_list_mp_pkg::*;
#(
  parameter int DATA_WIDTH  = FL_DATA_WIDTH,
  parameter int RAM_DEPTH   = FL_RAM_DEPTH,
  parameter int L_REGISTERS = FL_L_REGISTERS,
  parameter int PUSH_LANES  = 2,
  parameter int POP_LANES   = 2,
  parameter int CKPT_COUNT  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PUSH_LANES-1:0]            push,
  input  logic [PUSH_LANES*DATA_WIDTH-1:0] push_data,
  output logic                             ready,
  input  logic [POP_LANES-1:0]             pop,
  output logic [POP_LANES*DATA_WIDTH-1:0]  pop_data,
  output logic [POP_LANES-1:0]             pop_valid,
  input  logic                             ckpt_save,
  input  logic                             ckpt_restore,
  input  logic [$clog2(CKPT_COUNT)-1:0]    ckpt_id,
  output logic [$clog2(RAM_DEPTH):0]       count
);

  localparam int AW  = $clog2(RAM_DEPTH);
  localparam int PCW = $clog2(PUSH_LANES + 1);
  localparam int OCW = $clog2(POP_LANES + 1);

  tag_t mem_q  [RAM_DEPTH];
  ptr_t ckpt_q [CKPT_COUNT];
  ptr_t head_q, head_d, tail_q, tail_d, head_pop;

  logic [PUSH_LANES*PCW-1:0] push_off;
  logic [PCW-1:0]            push_cnt;
  logic [OCW-1:0]            pop_cnt;
  logic [AW-1:0]             wr_addr [PUSH_LANES];
  logic                      pop_thermo;

  lane_compactor #(
    .LANES (PUSH_LANES),
    .CW    (PCW)
  ) u_push_compactor (
    .mask_i   (push),
    .offset_o (push_off),
    .count_o  (push_cnt)
  );

  // Occupancy is the pointer distance; the extra wrap bit makes full != empty.
  assign count = tail_q - head_q;
  assign ready = (ptr_t'(RAM_DEPTH) - count) >= ptr_t'(PUSH_LANES);

  generate
    for (genvar i = 0; i < POP_LANES; i++) begin : g_pop_lane
      logic [AW-1:0] rd_addr;
      assign rd_addr                           = head_q[AW-1:0] + AW'(i);
      assign pop_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr];
      assign pop_valid[i]                      = count > ptr_t'(i);
    end
  endgenerate

  always_comb begin
    pop_cnt    = '0;
    pop_thermo = 1'b1;
    for (int i = 0; i < POP_LANES; i++) begin
      pop_cnt = pop_cnt + OCW'(pop[i]);
      if (i > 0 && pop[i] && !pop[i-1]) pop_thermo = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < PUSH_LANES; i++) begin
      wr_addr[i] = tail_q[AW-1:0] + AW'(push_off[i*PCW +: PCW]);
    end
  end

  // A restore overrides this cycle's pops; pushes still land at the tail.
  assign head_pop = head_q + ptr_t'(pop_cnt);
  assign head_d   = ckpt_restore ? ckpt_q[ckpt_id] : head_pop;
  assign tail_d   = tail_q + ptr_t'(push_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= RST_HEAD;
      tail_q <= ptr_t'(RAM_DEPTH - L_REGISTERS);
      for (int k = 0; k < CKPT_COUNT; k++) ckpt_q[k] <= '0;
      for (int j = 0; j < RAM_DEPTH; j++) begin
        mem_q[j] <= (j < RAM_DEPTH - L_REGISTERS) ? reset_tag(j, L_REGISTERS) : '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (ckpt_save && !ckpt_restore) ckpt_q[ckpt_id] <= head_pop;
      for (int i = 0; i < PUSH_LANES; i++) begin
        if (push[i]) mem_q[wr_addr[i]] <= tag_t'(push_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  a_lanes_nonzero : assert property (@(posedge clk) (PUSH_LANES > 0) && (POP_LANES > 0))
    else $error("free_list_mp: lane count of zero");
  a_pop_valid : assert property (@(posedge clk) disable iff (rst) (pop & ~pop_valid) == '0)
    else $error("free_list_mp: pop on a lane without pop_valid");
  a_pop_thermo : assert property (@(posedge clk) disable iff (rst) pop_thermo)
    else $error("free_list_mp: non-thermometer pop mask");
  a_push_ready : assert property (@(posedge clk) disable iff (rst) !((|push) && !ready))
    else $error("free_list_mp: push while not ready");

endmodule

`default_nettype wire

// File: tb/tb_free_list_mp.sv
// ============================================================================
// Module  : tb_free_list_mp
// Brief   : Directed and random scoreboard bench for free_list_mp.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_free_list_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  push = '0;
  logic [13:0] push_data = '0;
  logic        ready;
  logic [1:0]  pop = '0;
  logic [13:0] pop_data;
  logic [1:0]  pop_valid;
  logic        ckpt_save = 1'b0;
  logic        ckpt_restore = 1'b0;
  logic [1:0]  ckpt_id = '0;
  logic [7:0]  count;

  free_list_mp dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_data    (push_data),
    .ready        (ready),
    .pop          (pop),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .ckpt_id      (ckpt_id),
    .count        (count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Scoreboard: q holds tags in the order the DUT must present them.
  int q[$];
  int pool[$];
  int snap_v[4][128];
  int snap_n[4];
  int since_v[4][512];
  int since_n[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pool.delete();
    for (int j = 32; j < 128; j++) q.push_back(j);
    for (int j = 0; j < 32; j++) pool.push_back(j);
    for (int k = 0; k < 4; k++) begin
      snap_n[k]  = 96;
      since_n[k] = 0;
      for (int j = 0; j < 96; j++) snap_v[k][j] = j + 32;
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("ready", 32'(ready), 32'((128 - n) >= 2));
    chk("pop_valid", 32'(pop_valid), {30'd0, n > 1, n > 0});
    if (n > 0) chk("pop_data0", 32'(pop_data[6:0]), 32'(q[0]));
    if (n > 1) chk("pop_data1", 32'(pop_data[13:7]), 32'(q[1]));
  endtask

  task automatic cycle(input logic [1:0] pu, input int d0, input int d1, input logic [1:0] po,
                       input logic sv, input logic rs, input int id);
    int tg[2];
    tg[0] = d0;
    tg[1] = d1;
    push = pu;
    push_data = {7'(d1), 7'(d0)};
    pop = po;
    ckpt_save = sv;
    ckpt_restore = rs;
    ckpt_id = 2'(id);
    @(posedge clk);
    if (rs) begin
      q.delete();
      for (int j = 0; j < snap_n[id]; j++) q.push_back(snap_v[id][j]);
      for (int j = 0; j < since_n[id]; j++) q.push_back(since_v[id][j]);
    end else begin
      for (int i = 0; i < 2; i++) if (po[i] && q.size() > 0) pool.push_back(q.pop_front());
      if (sv) begin
        snap_n[id] = q.size();
        for (int j = 0; j < q.size(); j++) snap_v[id][j] = q[j];
        since_n[id] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (pu[i]) begin
        q.push_back(tg[i]);
        for (int k = 0; k < 4; k++) if (since_n[k] < 512) begin
          since_v[k][since_n[k]] = tg[i];
          since_n[k]++;
        end
      end
    end
    #1;
    push = '0; pop = '0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input logic busy);
    if (busy) begin
      push = 2'b11; push_data = {7'd3, 7'd4}; pop = 2'b11; ckpt_save = 1'b1; ckpt_id = 2'd2;
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    push = '0; pop = '0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    chk("rst_pop_data", 32'(pop_data), 32'({7'd33, 7'd32}));
    rst = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int n, np, d0, d1, bad;
    logic [1:0] pu, pm;
    int seen[128];

    model_reset();
    @(negedge clk);
    do_reset(1'b0);
    chk("rst_count", 32'(count), 32'd96);
    chk("rst_valid", 32'(pop_valid), 32'd3);
    chk("rst_ready", 32'(ready), 32'd1);

    // Single then dual pop
    cycle(2'b00, 0, 0, 2'b01, 0, 0, 0);
    chk("pop1_data0", 32'(pop_data[6:0]), 32'd33);
    cycle(2'b00, 0, 0, 2'b11, 0, 0, 0);
    chk("pop2_data0", 32'(pop_data[6:0]), 32'd35);
    chk("pop2_count", 32'(count), 32'd93);

    // Upper-lane-only push compacts to the tail slot; drain to reach it
    do_reset(1'b1);
    cycle(2'b10, 0, 5, 2'b00, 0, 0, 0);
    chk("push1_count", 32'(count), 32'd97);
    for (int c = 0; c < 48; c++) cycle(2'b00, 0, 0, 2'b11, 0, 0, 0);
    chk("drain_data0", 32'(pop_data[6:0]), 32'd5);
    chk("drain_count", 32'(count), 32'd1);

    // Checkpoint save / restore
    do_reset(1'b0);
    cycle(2'b00, 0, 0, 2'b00, 1, 0, 2);
    for (int c = 0; c < 3; c++) cycle(2'b00, 0, 0, 2'b11, 0, 0, 0);
    cycle(2'b00, 0, 0, 2'b00, 0, 1, 2);
    chk("restore_data0", 32'(pop_data[6:0]), 32'd32);
    chk("restore_count", 32'(count), 32'd96);
    cycle(2'b00, 0, 0, 2'b01, 1, 0, 1);
    cycle(2'b00, 0, 0, 2'b11, 0, 0, 0);
    d0 = pool.pop_front();
    cycle(2'b01, d0, 0, 2'b11, 0, 1, 1);
    cycle(2'b00, 0, 0, 2'b11, 0, 0, 0);
    cycle(2'b00, 0, 0, 2'b11, 1, 1, 2);
    cycle(2'b00, 0, 0, 2'b11, 0, 0, 0);
    cycle(2'b00, 0, 0, 2'b00, 0, 1, 2);
    chk("save_ignored_data0", 32'(pop_data[6:0]), 32'd32);

    // Fill to full and exercise the ready boundary
    do_reset(1'b0);
    for (int c = 0; c < 16; c++) begin
      d0 = pool.pop_front();
      d1 = pool.pop_front();
      cycle(2'b11, d0, d1, 2'b00, 0, 0, 0);
    end
    chk("full_count", 32'(count), 32'd128);
    chk("full_ready", 32'(ready), 32'd0);
    cycle(2'b00, 0, 0, 2'b01, 0, 0, 0);
    chk("c127_ready", 32'(ready), 32'd0);
    cycle(2'b00, 0, 0, 2'b01, 0, 0, 0);
    chk("c126_ready", 32'(ready), 32'd1);
    d0 = pool.pop_front();
    d1 = pool.pop_front();
    cycle(2'b11, d0, d1, 2'b11, 0, 0, 0);
    chk("pushpop_count", 32'(count), 32'd126);

    // Random push/pop across the tail wrap, checking tag conservation
    do_reset(1'b0);
    for (int c = 0; c < 200; c++) begin
      n  = q.size();
      np = $urandom_range(0, 2);
      if (np > n) np = n;
      pm = (np == 0) ? 2'b00 : (np == 1) ? 2'b01 : 2'b11;
      pu = 2'b00; d0 = 0; d1 = 0;
      if ($urandom_range(0, 3) != 0 && (128 - n) >= 2) pu = 2'($urandom_range(1, 3));
      if (pu[0]) begin
        if (pool.size() > 0) d0 = pool.pop_front(); else pu[0] = 1'b0;
      end
      if (pu[1]) begin
        if (pool.size() > 0) d1 = pool.pop_front(); else pu[1] = 1'b0;
      end
      cycle(pu, d0, d1, pm, 0, 0, 0);
    end
    for (int j = 0; j < 128; j++) seen[j] = 0;
    for (int j = 0; j < q.size(); j++) seen[q[j]]++;
    for (int j = 0; j < pool.size(); j++) seen[pool[j]]++;
    bad = 0;
    for (int j = 0; j < 128; j++) if (seen[j] != 1) bad++;
    chk("conserve", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
